mem_port_arbiter: RTL and testbench

- Arbitrates the single unified memory bus between instruction fetch (IF) and data access (MEM).
- Generates the IF_Stall that holds the IF/ID pipeline register, and the MEM_Stall used by the MEM stage.
- Handles IF_Flush while a fetch is in flight by discarding the returned word, so a flushed fetch never reaches ID.
- Data accesses have priority; a starvation counter guarantees fetch progress.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/arb_starve_ctr.sv | 30 +++
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 tb/tb_mem_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the memory port arbiter: state encoding and parameter defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int CPU_ADDR_W     = 30;
  localparam int CPU_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_FETCH   = 2'd1,
    ARB_DATA    = 2'd2,
    ARB_DISCARD = 2'd3
  } arb_state_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants won while a fetch was waiting.
// Latency: count updates on the clock edge after inc/clr; at_limit is combinational from the count.
// Backpressure: none; clr wins over inc, inc is ignored once the count sits at MAX.
module arb_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int CW = $clog2(MAX + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] count;

  // Count up to MAX and hold there; a fetch grant clears it.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != MAX_C)) begin
      count <= count + 1'b1;
    end
  end

  assign at_limit = (count >= MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch and data access; data wins unless fetch is starved.
// Latency: request sampled in IDLE at n, Bus_Req from n+1, Ready pulse one cycle after Bus_Ack (3 cycles minimum).
// Backpressure: requesters hold their request until Ready; IF_Stall/MEM_Stall tell the pipeline to wait.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = CPU_ADDR_W,
  parameter int STARVE_MAX = CPU_STARVE_MAX
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              IF_Read,
  input  logic [ADDR_W-1:0] IF_Address,
  input  logic              IF_Flush,
  output logic [31:0]       IF_Instruction,
  output logic              IF_Ready,
  output logic              IF_Stall,
  input  logic              MEM_Read,
  input  logic [3:0]        MEM_Write,
  input  logic [ADDR_W-1:0] MEM_Address,
  input  logic [31:0]       MEM_DataOut,
  output logic [31:0]       MEM_DataIn,
  output logic              MEM_Ready,
  output logic              MEM_Stall,
  output logic              Bus_Req,
  output logic [3:0]        Bus_WE,
  output logic [ADDR_W-1:0] Bus_Address,
  output logic [31:0]       Bus_DataOut,
  input  logic [31:0]       Bus_DataIn,
  input  logic              Bus_Ack
);

  arb_state_e state, state_nxt;
  logic [3:0] we_q;
  logic       data_req, data_elig, fetch_elig;
  logic       grant_data, grant_fetch;
  logic       starve_limit;

  // A requester whose Ready pulse is showing is finishing, so it cannot be granted again this cycle.
  assign data_req    = MEM_Read | (|MEM_Write);
  assign data_elig   = data_req & ~MEM_Ready;
  assign fetch_elig  = IF_Read & ~IF_Flush & ~IF_Ready;
  assign grant_data  = (state == ARB_IDLE) & data_elig & (~starve_limit | ~fetch_elig);
  assign grant_fetch = (state == ARB_IDLE) & ~grant_data & fetch_elig;

  assign IF_Stall  = IF_Read & ~IF_Ready;
  assign MEM_Stall = data_req & ~MEM_Ready;
  assign Bus_Req   = (state != ARB_IDLE);
  assign Bus_WE    = (state == ARB_DATA) ? we_q : 4'b0000;

  arb_starve_ctr #(
    .MAX(STARVE_MAX)
  ) u_starve (
    .clock   (clock),
    .reset   (reset),
    .inc     (grant_data & fetch_elig),
    .clr     (grant_fetch),
    .at_limit(starve_limit)
  );

  // Next-state: Bus_Req stays up until Bus_Ack; a flushed fetch drains through DISCARD.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (grant_data) begin
          state_nxt = ARB_DATA;
        end else if (grant_fetch) begin
          state_nxt = ARB_FETCH;
        end
      end
      ARB_FETCH: begin
        if (Bus_Ack) begin
          state_nxt = ARB_IDLE;
        end else if (IF_Flush) begin
          state_nxt = ARB_DISCARD;
        end
      end
      ARB_DATA:    if (Bus_Ack) state_nxt = ARB_IDLE;
      ARB_DISCARD: if (Bus_Ack) state_nxt = ARB_IDLE;
      default:     state_nxt = ARB_IDLE;
    endcase
  end

  // State, completion pulses, captured read data and the latched bus command.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ARB_IDLE;
      IF_Ready       <= 1'b0;
      MEM_Ready      <= 1'b0;
      IF_Instruction <= '0;
      MEM_DataIn     <= '0;
      Bus_Address    <= '0;
      Bus_DataOut    <= '0;
      we_q           <= '0;
    end else begin
      state     <= state_nxt;
      IF_Ready  <= (state == ARB_FETCH) & Bus_Ack & ~IF_Flush;
      MEM_Ready <= (state == ARB_DATA) & Bus_Ack;
      if ((state == ARB_FETCH) && Bus_Ack && !IF_Flush) begin
        IF_Instruction <= Bus_DataIn;
      end
      if ((state == ARB_DATA) && Bus_Ack) begin
        MEM_DataIn <= Bus_DataIn;
      end
      if (grant_data) begin
        Bus_Address <= MEM_Address;
        Bus_DataOut <= MEM_DataOut;
        we_q        <= MEM_Write;
      end else if (grant_fetch) begin
        Bus_Address <= IF_Address;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a bus-ownership model checked every cycle.
// Latency: slave acks after a programmable number of Bus_Req cycles (0 = first cycle).
// Backpressure: requesters are held until their Ready pulse, as the pipeline would.
module tb_mem_port_arbiter;

  localparam int AW   = 30;
  localparam int SMAX = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          IF_Read = 1'b0, IF_Flush = 1'b0;
  logic [AW-1:0] IF_Address = '0;
  logic [31:0]   IF_Instruction;
  logic          IF_Ready, IF_Stall;
  logic          MEM_Read = 1'b0;
  logic [3:0]    MEM_Write = 4'h0;
  logic [AW-1:0] MEM_Address = '0;
  logic [31:0]   MEM_DataOut = '0;
  logic [31:0]   MEM_DataIn;
  logic          MEM_Ready, MEM_Stall;
  logic          Bus_Req;
  logic [3:0]    Bus_WE;
  logic [AW-1:0] Bus_Address;
  logic [31:0]   Bus_DataOut;
  logic [31:0]   Bus_DataIn;
  logic          Bus_Ack;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
    .clock(clock), .reset(reset),
    .IF_Read(IF_Read), .IF_Address(IF_Address), .IF_Flush(IF_Flush),
    .IF_Instruction(IF_Instruction), .IF_Ready(IF_Ready), .IF_Stall(IF_Stall),
    .MEM_Read(MEM_Read), .MEM_Write(MEM_Write), .MEM_Address(MEM_Address),
    .MEM_DataOut(MEM_DataOut), .MEM_DataIn(MEM_DataIn), .MEM_Ready(MEM_Ready),
    .MEM_Stall(MEM_Stall), .Bus_Req(Bus_Req), .Bus_WE(Bus_WE),
    .Bus_Address(Bus_Address), .Bus_DataOut(Bus_DataOut),
    .Bus_DataIn(Bus_DataIn), .Bus_Ack(Bus_Ack)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clock);
  endtask

  // Bus slave: acks after ack_delay Req cycles; read data is rd_data xor the bus address.
  int          ack_delay = 0;
  logic [31:0] rd_data = '0;
  int          req_cnt = 0;
  initial begin
    Bus_Ack    = 1'b0;
    Bus_DataIn = '0;
    forever begin
      @(negedge clock);
      if (reset || !Bus_Req) begin
        req_cnt = 0;
        Bus_Ack = 1'b0;
      end else begin
        Bus_Ack = (req_cnt == ack_delay);
        req_cnt++;
      end
      Bus_DataIn = rd_data ^ {2'b00, Bus_Address};
    end
  end

  // Model: who owns the bus (0 none, 1 fetch, 2 data, 3 dropped fetch) plus the starvation tally.
  bit            m_valid = 0;
  int            m_owner = 0, m_starve = 0;
  bit            m_ifr = 0, m_memr = 0, ifr_n, memr_n, d_el, f_el;
  logic [31:0]   m_instr, m_din, m_dout;
  logic [AW-1:0] m_addr;
  logic [3:0]    m_we;
  initial begin
    forever begin
      @(posedge clock);
      if (reset) begin
        m_valid = 1; m_owner = 0; m_starve = 0; m_ifr = 0; m_memr = 0;
        m_instr = '0; m_din = '0; m_dout = '0; m_addr = '0; m_we = '0;
      end else if (m_valid) begin
        ifr_n = 0; memr_n = 0;
        case (m_owner)
          0: begin
            d_el = (MEM_Read || MEM_Write != 4'd0) && !m_memr;
            f_el = IF_Read && !IF_Flush && !m_ifr;
            if (d_el && (m_starve < SMAX || !f_el)) begin
              m_owner = 2; m_addr = MEM_Address; m_dout = MEM_DataOut; m_we = MEM_Write;
              if (f_el) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
            end else if (f_el) begin
              m_owner = 1; m_addr = IF_Address; m_starve = 0;
            end
          end
          1: begin
            if (Bus_Ack) begin
              if (!IF_Flush) begin m_instr = Bus_DataIn; ifr_n = 1; end
              m_owner = 0;
            end else if (IF_Flush) begin
              m_owner = 3;
            end
          end
          2: if (Bus_Ack) begin m_din = Bus_DataIn; memr_n = 1; m_owner = 0; end
          default: if (Bus_Ack) m_owner = 0;
        endcase
        m_ifr = ifr_n; m_memr = memr_n;
      end
      #1;
      if (m_valid) begin
        chk("cyc_if_ready",  IF_Ready, m_ifr);
        chk("cyc_if_instr",  IF_Instruction, m_instr);
        chk("cyc_mem_ready", MEM_Ready, m_memr);
        chk("cyc_mem_din",   MEM_DataIn, m_din);
        chk("cyc_bus_req",   Bus_Req, m_owner != 0);
        chk("cyc_bus_we",    Bus_WE, (m_owner == 2) ? m_we : 4'h0);
        chk("cyc_bus_addr",  Bus_Address, m_addr);
        chk("cyc_bus_dout",  Bus_DataOut, m_dout);
        chk("cyc_if_stall",  IF_Stall, IF_Read && !m_ifr);
        chk("cyc_mem_stall", MEM_Stall, (MEM_Read || MEM_Write != 4'd0) && !m_memr);
      end
    end
  end

  int  done, data_grants, first_fetch_after;
  bit  fetch_seen, prev_req;

  // Directed scenarios with hand-computed expectations.
  initial begin
    repeat (3) tick;
    chk("rst_bus_req", Bus_Req, 0);
    chk("rst_if_ready", IF_Ready, 0);
    chk("rst_mem_ready", MEM_Ready, 0);
    chk("rst_instr", IF_Instruction, 0);
    chk("rst_bus_addr", Bus_Address, 0);
    reset = 1'b0;
    tick;

    // Fetch alone, ack in the first Req cycle.
    rd_data = 32'h2402_0005 ^ 32'h100; ack_delay = 0;
    IF_Read = 1'b1; IF_Address = 'h100;
    tick;
    chk("t1_req", Bus_Req, 1);
    chk("t1_ready_early", IF_Ready, 0);
    chk("t1_stall_wait", IF_Stall, 1);
    tick;
    chk("t1_ready", IF_Ready, 1);
    chk("t1_instr", IF_Instruction, 32'h2402_0005);
    chk("t1_stall_low", IF_Stall, 0);
    chk("t1_req_off", Bus_Req, 0);
    IF_Read = 1'b0;
    tick;

    // Store and fetch together: store goes first, fetch right after MEM_Ready.
    rd_data = 32'h5555_0000; ack_delay = 1;
    IF_Read = 1'b1; IF_Address = 'h200;
    MEM_Write = 4'hF; MEM_Address = 'h40; MEM_DataOut = 32'hDEAD_BEEF;
    tick;
    chk("t2_req", Bus_Req, 1);
    chk("t2_we", Bus_WE, 4'hF);
    chk("t2_addr", Bus_Address, 'h40);
    chk("t2_dout", Bus_DataOut, 32'hDEAD_BEEF);
    tick;
    tick;
    chk("t2_mem_ready", MEM_Ready, 1);
    chk("t2_if_not_ready", IF_Ready, 0);
    MEM_Write = 4'h0;
    tick;
    chk("t2_fetch_req", Bus_Req, 1);
    chk("t2_fetch_addr", Bus_Address, 'h200);
    chk("t2_fetch_we", Bus_WE, 4'h0);
    tick;
    tick;
    chk("t2_if_ready", IF_Ready, 1);
    chk("t2_instr", IF_Instruction, 32'h5555_0200);
    IF_Read = 1'b0;
    tick;

    // Starvation: loads back to back, fetch held; flush masks the fetch in each MEM_Ready gap.
    rd_data = 32'h1111_2222; ack_delay = 0;
    IF_Read = 1'b1; IF_Address = 'h300;
    MEM_Read = 1'b1; MEM_Address = 'h1000;
    done = 0; data_grants = 0; first_fetch_after = -1; fetch_seen = 0; prev_req = 0;
    for (int cyc = 0; cyc < 200 && (done < 10 || IF_Read); cyc++) begin
      tick;
      if (Bus_Req && !prev_req) begin
        if (Bus_Address == 'h300) begin
          if (!fetch_seen) first_fetch_after = data_grants;
          fetch_seen = 1;
        end else begin
          data_grants++;
        end
      end
      prev_req = Bus_Req;
      IF_Flush = 1'b0;
      if (MEM_Ready) begin
        done++;
        if (done < 10) MEM_Address = AW'('h1000 + done);
        else MEM_Read = 1'b0;
        if (IF_Read) IF_Flush = 1'b1;
      end
      if (IF_Ready) IF_Read = 1'b0;
    end
    IF_Flush = 1'b0; IF_Read = 1'b0; MEM_Read = 1'b0;
    chk("t3_loads_done", done, 10);
    chk("t3_fetch_seen", fetch_seen, 1);
    chk("t3_data_before_fetch", first_fetch_after, 4);
    chk("t3_data_grants", data_grants, 10);
    chk("t3_instr", IF_Instruction, 32'h1111_2122);
    tick;

    // Flush while the fetch is waiting: bus held until ack, word dropped.
    rd_data = 32'hBAD0_0001; ack_delay = 3;
    IF_Read = 1'b1; IF_Address = 'h400;
    tick;
    chk("t4_req", Bus_Req, 1);
    IF_Flush = 1'b1;
    tick;
    IF_Flush = 1'b0; IF_Read = 1'b0;
    chk("t4_hold1", Bus_Req, 1);
    tick;
    chk("t4_hold2", Bus_Req, 1);
    tick;
    chk("t4_hold3", Bus_Req, 1);
    tick;
    chk("t4_released", Bus_Req, 0);
    chk("t4_no_ready", IF_Ready, 0);
    chk("t4_instr_kept", IF_Instruction, 32'h1111_2122);
    tick;
    chk("t4_no_ready_late", IF_Ready, 0);

    // Flush coincident with ack, then a fresh fetch completes normally.
    rd_data = 32'hBAD0_0002; ack_delay = 1;
    IF_Read = 1'b1; IF_Address = 'h500;
    tick;
    chk("t5_req", Bus_Req, 1);
    tick;
    IF_Flush = 1'b1;
    tick;
    IF_Flush = 1'b0;
    chk("t5_no_ready", IF_Ready, 0);
    chk("t5_req_off", Bus_Req, 0);
    chk("t5_instr_kept", IF_Instruction, 32'h1111_2122);
    IF_Address = 'h504; rd_data = 32'h3333_4444 ^ 32'h504; ack_delay = 0;
    tick;
    chk("t5_new_req", Bus_Req, 1);
    chk("t5_new_addr", Bus_Address, 'h504);
    tick;
    chk("t5_new_ready", IF_Ready, 1);
    chk("t5_new_instr", IF_Instruction, 32'h3333_4444);
    IF_Read = 1'b0;
    tick;

    // Reset while a load waits for its ack.
    rd_data = 32'h7777_0000; ack_delay = 5;
    MEM_Read = 1'b1; MEM_Address = 'h600;
    tick;
    chk("t6_req", Bus_Req, 1);
    reset = 1'b1;
    tick;
    chk("t6_req_off", Bus_Req, 0);
    chk("t6_no_ready", MEM_Ready, 0);
    chk("t6_instr", IF_Instruction, 0);
    chk("t6_din", MEM_DataIn, 0);
    chk("t6_addr", Bus_Address, 0);
    chk("t6_we", Bus_WE, 0);
    chk("t6_dout", Bus_DataOut, 0);
    reset = 1'b0; MEM_Read = 1'b0;
    tick;
    chk("t6_still_no_ready", MEM_Ready, 0);
    chk("t6_still_idle", Bus_Req, 0);
    repeat (2) tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
